// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the alu_mdu execution unit.
//   alu_op_e    - 5-bit operation codes (base ALU ops 0-9, RV32M ops 16-23)
//   alu_state_e - control FSM states
//   is_mdu_op() - true for the iterative multiply/divide op codes
//   is_div_op() - true for the divide/remainder subset of the M ops
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLT    = 5'd5,
        OP_SLTU   = 5'd6,
        OP_SLL    = 5'd7,
        OP_SRL    = 5'd8,
        OP_SRA    = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    // M ops occupy codes 16..23, i.e. op[4:3] == 2'b10.
    function automatic logic is_mdu_op(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    // Within the M ops, bit 2 separates divide/remainder from multiply.
    function automatic logic is_div_op(input logic [4:0] op);
        return is_mdu_op(op) && op[2];
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle between the execute-stage controller
// (master) and the alu_mdu unit (slave).
//   valid_i/op_i/a_i/b_i : request, accepted when valid_i && ready_o
//   ready_o              : unit idle
//   valid_o/rslt_o/zero_o: one-cycle result pulse, registered result, result==0
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [4:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] rslt_o;
    logic             zero_o;

    modport master (
        output valid_i, op_i, a_i, b_i,
        input  ready_o, valid_o, rslt_o, zero_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i,
        output ready_o, valid_o, rslt_o, zero_o
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide datapath on unsigned magnitudes.
//   clk, reset : clock, async active-high reset (aborts any operation)
//   start      : load a_mag/b_mag and begin a new operation
//   op         : op code sampled at start (selects multiply or divide step)
//   a_mag      : multiplier / dividend magnitude
//   b_mag      : multiplicand / divisor magnitude
//   done       : the step being applied this cycle is the last one
//   acc_next   : accumulator after this cycle's step; on done it holds the
//                full product {hi,lo} or {remainder,quotient}
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  alu_op_e            op,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic               done,
    output logic [2*WIDTH-1:0] acc_next
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               div_q, div_d;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

    // One step per cycle.
    // Multiply: acc = {partial, multiplier}; add b when the low multiplier
    //   bit is set, then shift right (the carry enters at the top).
    // Divide: acc = {remainder, dividend}; shift left one bit into the
    //   remainder, subtract the divisor if it fits and record a quotient bit.
    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff  = trial - {1'b0, b_q};
        if (div_q) begin
            // diff[WIDTH] is the borrow: set when trial < divisor.
            if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else              acc_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_next = {sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;
        if (start) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            b_d    = b_mag;
            cnt_d  = '0;
            busy_d = 1'b1;
            div_d  = is_div_op(op);
        end else if (busy_q) begin
            acc_d = acc_next;
            cnt_d = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    // NOTE: the datapath registers are reset as well as the control bits; they are plain flops, and it keeps acc_next free of X after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            acc_q  <= acc_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: RV32I ALU + RV32M multiply/divide execution unit.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset; aborts any operation in flight
//   bus   : alu_mdu_if slave port
//           valid_i/op_i/a_i/b_i request (accepted when valid_i && ready_o)
//           ready_o idle, valid_o one-cycle result pulse,
//           rslt_o registered result, zero_o = (rslt_o == 0)
// Base ops and M-op special cases respond one cycle after acceptance;
// other M ops respond WIDTH+1 cycles after acceptance.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      reset,
    alu_mdu_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] rslt_q, rslt_d;
    alu_op_e          op_q, op_d;
    logic             neg_q, neg_d;

    alu_op_e            op_in;
    logic [WIDTH-1:0]   a, b, base_res, a_mag, b_mag, special_res, mdu_res;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] acc_next, prod;
    logic               a_neg, b_neg, neg_in, special, mdu_start, mdu_done;

    assign op_in = alu_op_e'(bus.op_i);
    assign a     = bus.a_i;
    assign b     = bus.b_i;

    always_comb begin
        case (op_in)
            OP_ADD:  base_res = a + b;
            OP_SUB:  base_res = a - b;
            OP_AND:  base_res = a & b;
            OP_OR:   base_res = a | b;
            OP_XOR:  base_res = a ^ b;
            OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  base_res = a << b[SHW-1:0];
            OP_SRL:  base_res = a >> b[SHW-1:0];
            OP_SRA:  base_res = $unsigned($signed(a) >>> b[SHW-1:0]);
            default: base_res = '0;
        endcase
    end

    // The iterative core works on magnitudes; the sign of the final result
    // is remembered in neg_q and applied on the way into rslt_q.
    always_comb begin
        a_neg  = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[WIDTH-1];
        b_neg  = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        // Remainder follows the dividend; everything else is the XOR of signs.
        neg_in = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);

        special     = 1'b0;
        special_res = '0;
        if (is_div_op(op_in)) begin
            if (b == '0) begin
                special     = 1'b1;
                special_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : a;
            end else if ((op_in inside {OP_DIV, OP_REM}) && a == MIN_INT && b == '1) begin
                special     = 1'b1;
                special_res = (op_in == OP_DIV) ? MIN_INT : '0;
            end
        end
    end

    mdu_iter #(.WIDTH(WIDTH)) u_mdu_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (mdu_start),
        .op       (op_in),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .done     (mdu_done),
        .acc_next (acc_next)
    );

    // Quotient and remainder are negated independently; a product is
    // negated as one 2*WIDTH value so the borrow reaches the high half.
    always_comb begin
        prod = neg_q ? -acc_next : acc_next;
        quo  = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem  = neg_q ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:           mdu_res = prod[WIDTH-1:0];
            OP_DIV, OP_DIVU:  mdu_res = quo;
            OP_REM, OP_REMU:  mdu_res = rem;
            default:          mdu_res = prod[2*WIDTH-1:WIDTH];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rslt_d    = rslt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        mdu_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.valid_i) begin
                    state_d = S_DONE;
                    if (!is_mdu_op(op_in)) begin
                        rslt_d = base_res;
                    end else if (special) begin
                        rslt_d = special_res;
                    end else begin
                        mdu_start = 1'b1;
                        op_d      = op_in;
                        neg_d     = neg_in;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (mdu_done) begin
                    rslt_d  = mdu_res;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rslt_q  <= '0;
            op_q    <= OP_ADD;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rslt_q  <= rslt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.ready_o = (state_q == S_IDLE);
    assign bus.valid_o = (state_q == S_DONE);
    assign bus.rslt_o  = rslt_q;
    assign bus.zero_o  = (rslt_q == '0);

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed-vector scoreboard bench for alu_mdu (WIDTH=32).
// The driver pushes the hand-computed result and the cycle in which valid_o
// must appear; a monitor on the falling edge pops and compares every
// valid_o pulse against the queue head.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] rslt;
        int           cyc;
        string        name;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_miscmp;
    exp_t sb[$];

    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every valid_o pulse must match the oldest outstanding vector.
    always @(negedge clk) begin
        if (bus.valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_valid_o", 32'(bus.valid_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_rslt"}, bus.rslt_o, e.rslt);
                check({e.name, "_zero"}, 32'(bus.zero_o), 32'(e.rslt == '0));
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, then drop valid_i.
    // lat is the number of cycles from the acceptance edge to valid_o
    // beyond the first one (0 for base ops/special cases, W for M ops).
    task automatic issue(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat, input string name,
                         input bit expect_out = 1'b1);
        int n;
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        n = 0;
        @(negedge clk);
        while (!bus.ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({name, "_accept_timeout"}, 32'(n), 32'd0);
        if (expect_out) sb.push_back('{exp, cyc + 1 + lat, name});
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    initial begin
        int n;
        int ready_seen;
        n_vec       = 0;
        n_miscmp    = 0;
        cyc         = 0;
        reset       = 1'b1;
        bus.valid_i = 1'b0;
        bus.op_i    = '0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_rslt", bus.rslt_o, 32'd0);
        check("rst_zero", 32'(bus.zero_o), 32'd1);
        @(posedge clk);
        #1;

        // Base ops, back to back at the maximum issue rate.
        issue(OP_SUB,  32'd5,        32'd5,        32'd0,        0, "sub_5_5");
        issue(OP_SRA,  32'h80000000, 32'd4,        32'hF8000000, 0, "sra");
        issue(OP_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        0, "sltu");
        issue(OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        0, "slt");
        issue(OP_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        0, "add_wrap");
        issue(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, "xor");
        issue(OP_SLL,  32'd1,        32'd33,       32'd2,        0, "sll_shamt");
        issue(OP_SRL,  32'h80000000, 32'd31,       32'd1,        0, "srl");
        issue(alu_op_e'(5'd12), 32'd7, 32'd9,      32'd0,        0, "undef_op");

        // Multiply.
        issue(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, W, "mulh_min");
        issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, W, "mulhu_max");
        issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, W, "mul_7_m3");
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, W, "mulhsu");

        // Divide.
        issue(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, W, "div_m7_2");
        issue(OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, W, "rem_m7_2");
        issue(OP_DIVU, 32'd100,      32'd7, 32'd14,       W, "divu_100_7");
        issue(OP_REMU, 32'd100,      32'd7, 32'd2,        W, "remu_100_7");

        // Special cases, single-cycle.
        issue(OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 0, "divu_by0");
        issue(OP_REMU, 32'd5,        32'd0,        32'd5,        0, "remu_by0");
        issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf");
        issue(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        0, "rem_ovf");

        // Abort: reset 10 cycles into a DIV must suppress its result.
        issue(OP_DIV, 32'd1000, 32'd3, 32'd0, W, "div_abort", 1'b0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        check("abort_ready", 32'(bus.ready_o), 32'd1);
        check("abort_valid", 32'(bus.valid_o), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (W + 8) @(posedge clk);
        #1;

        // valid_i held high across a whole MUL: one result, no early re-issue.
        bus.valid_i = 1'b1;
        bus.op_i    = OP_MUL;
        bus.a_i     = 32'd3;
        bus.b_i     = 32'd4;
        @(negedge clk);
        sb.push_back('{32'd12, cyc + 1 + W, "mul_held"});
        @(posedge clk);
        n          = 0;
        ready_seen = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.ready_o) ready_seen++;
        end while (!bus.valid_o && n < 100);
        check("held_ready_low", 32'(ready_seen), 32'd0);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("held_idle_ready", 32'(bus.ready_o), 32'd1);

        // Drain the scoreboard, bounded.
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised-width integer execution unit for the next processor generation. Covers the full RV32I ALU op set (adds XOR, SLTU and shifts) plus the RV32M multiply/divide set. Base ops are registered with 1-cycle latency. M ops run on an iterative radix-2 datapath and take WIDTH+1 cycles. Sits in the execute stage of the multi-cycle/pipelined core behind a valid/ready handshake; the controller stalls while ready_o is low.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of 2 and at least 8
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk      input   1      clock, rising edge
reset    input   1      asynchronous active-high reset
valid_i  input   1      request; accepted only when valid_i && ready_o
op_i     input   5      operation code (alu_op_e)
a_i      input   WIDTH  operand A (rs1)
b_i      input   WIDTH  operand B (rs2/imm)
ready_o  output  1      unit idle, can accept a request this cycle
valid_o  output  1      one-cycle pulse, rslt_o valid
rslt_o   output  WIDTH  registered result
zero_o   output  1      rslt_o == 0

Behaviour:
- Reset: asynchronous, active-high. State=IDLE, rslt_o=0, valid_o=0, zero_o=1, ready_o=1.
- Reset mid-operation aborts the operation and produces no valid_o.
- Op codes, base ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9. Codes 0–3 and 5 keep the legacy 3-bit ALUControl meaning.
- Op codes, M ops: MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
- Any other op code: result 0, base-op latency.
- Arithmetic: modulo 2^WIDTH. Shifts use b_i[SHW-1:0]. SLT/SLTU give {0…,1} or 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: ready_o=1. Accepting a base op goes to DONE with the result registered. Accepting an M op latches operand magnitudes and sign flags, clears the counter, and goes to CALC. M-op special cases skip CALC and go straight to DONE.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle. Exits to DONE after WIDTH steps; the counter reaching WIDTH-1 is the exit condition. Sign correction is applied on the DONE transition.
  - DONE: valid_o=1, ready_o=0, rslt_o updated. Next state is IDLE unconditionally; there is no back-pressure.
- Latency, with acceptance at cycle N: base op and M special cases give valid_o at N+1. Other M ops give valid_o at N+WIDTH+1.
- Issue rate: at most one request every 2 cycles for base ops.
- valid_i while ready_o=0 is ignored; the bench must not rely on it being queued.
- Multiply: MUL returns the low WIDTH bits of the product. MULH, MULHSU and MULHU return the high WIDTH bits of the signed×signed, signed×unsigned and unsigned×unsigned 2·WIDTH product respectively.
- Divide: truncates toward zero. Remainder takes the sign of the dividend.
- Division by zero: DIV/DIVU return all-ones; REM/REMU return a_i.
- Signed overflow (a_i=MIN_INT, b_i=-1): DIV returns MIN_INT; REM returns 0.
- Between operations: rslt_o and zero_o hold their last value. zero_o is combinational from rslt_o.

Decomposition:
- Package alu_pkg: alu_op_e enum (5-bit, codes above), state enum alu_state_e, helper function is_mdu_op().
- Sub-module mdu_iter: iterative multiply/divide datapath (2·WIDTH accumulator, counter, step logic), controlled by start/op/done.
- Top alu_mdu: FSM, base-op combinational unit, special-case detection, sign fix-up, output registers.

Test Plan (WIDTH=32):
- Reset: after reset release, ready_o=1, valid_o=0, rslt_o=0, zero_o=1.
- Base op: SUB 5−5 accepted at cycle N → valid_o at N+1, rslt_o=0, zero_o=1. SRA 0x80000000>>4 → 0xF8000000. SLTU 1<0xFFFFFFFF → 1.
- Multiply: MULH 0x80000000×0x80000000 → 0x40000000, valid_o at N+33. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MUL 7×−3 → 0xFFFFFFEB.
- Divide: DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases at N+1: DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0 with zero_o=1.
- Abort and handshake: reset asserted 10 cycles into a DIV → no valid_o, ready_o=1 next cycle. valid_i held high throughout a MUL → exactly one valid_o, and no second op starts before IDLE.
